// File: rtl/line_fill_unit.sv
// Cache miss-service stage: optional dirty-victim writeback, beat-wise line fill,
// then a single-cycle commit of the assembled line into the data array.
module line_fill_unit #(
  parameter int WIDTH      = 128,
  parameter int BEAT_WIDTH = 64,
  localparam int BEATS     = WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_index,
  input  logic                  req_wb,
  input  logic [11:0]           req_fill_line,
  input  logic [11:0]           req_victim_line,
  input  logic [WIDTH-1:0]      req_victim_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [15:0]           mem_addr,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  arr_write,
  output logic [2:0]            arr_index,
  output logic [WIDTH-1:0]      arr_datain,
  output logic                  done
);

  localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [KW-1:0]   k_r;
  logic [2:0]      index_r;
  logic [11:0]     fill_line_r;
  logic [11:0]     victim_line_r;
  logic [WIDTH-1:0] victim_r;
  logic [WIDTH-1:0] buf_r;
  logic            last_beat_s;

  assign last_beat_s = (k_r == KW'(BEATS - 1));

  // Next-state decode; responses only advance the machine while a beat is outstanding
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = req_wb ? WB : FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WB: begin
        if (mem_resp && last_beat_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = WB;
        end
      end
      FILL: begin
        if (mem_resp && last_beat_s) begin
          state_nxt_s = COMMIT;
        end else begin
          state_nxt_s = FILL;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode purely from registered state, so outputs hold steady within a beat
  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = '0;
    arr_write  = 1'b0;
    done       = 1'b0;
    arr_index  = index_r;
    arr_datain = buf_r;
    case (state_r)
      IDLE: req_ready = 1'b1;
      WB: begin
        mem_write = 1'b1;
        mem_addr  = {victim_line_r, 4'b0000} + 16'(k_r) * 16'(BEAT_WIDTH / 8);
        mem_wdata = victim_r[int'(k_r) * BEAT_WIDTH +: BEAT_WIDTH];
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {fill_line_r, 4'b0000} + 16'(k_r) * 16'(BEAT_WIDTH / 8);
      end
      COMMIT: begin
        arr_write = 1'b1;
        done      = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // State, beat counter, captured request and assembly buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      k_r           <= '0;
      index_r       <= 3'd0;
      fill_line_r   <= 12'h000;
      victim_line_r <= 12'h000;
      victim_r      <= '0;
      buf_r         <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            index_r       <= req_index;
            fill_line_r   <= req_fill_line;
            victim_line_r <= req_victim_line;
            victim_r      <= req_victim_data;
            k_r           <= '0;
          end
        end
        WB: begin
          if (mem_resp) begin
            k_r <= last_beat_s ? '0 : k_r + KW'(1);
          end
        end
        FILL: begin
          if (mem_resp) begin
            buf_r[int'(k_r) * BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
            k_r <= last_beat_s ? '0 : k_r + KW'(1);
          end
        end
        default: k_r <= k_r;
      endcase
    end
  end

endmodule
